// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encodings, fixed op latencies and completion-FSM state encoding.
package fpu_pkg;

  localparam logic [3:0] FOP_ADD   = 4'b0000;
  localparam logic [3:0] FOP_SUB   = 4'b0001;
  localparam logic [3:0] FOP_MUL   = 4'b0010;
  localparam logic [3:0] FOP_FMA   = 4'b0011;
  localparam logic [3:0] FOP_SGNJ  = 4'b0100;
  localparam logic [3:0] FOP_MINMX = 4'b0101;
  localparam logic [3:0] FOP_DIV   = 4'b0110;
  localparam logic [3:0] FOP_CMP   = 4'b0111;
  localparam logic [3:0] FOP_F2I   = 4'b1000;
  localparam logic [3:0] FOP_9     = 4'b1001;

  localparam int unsigned LAT_ADD   = 7;
  localparam int unsigned LAT_SUB   = 7;
  localparam int unsigned LAT_MUL   = 5;
  localparam int unsigned LAT_FMA   = 6;
  localparam int unsigned LAT_SGNJ  = 0;
  localparam int unsigned LAT_MINMX = 1;
  localparam int unsigned LAT_DIV   = 16;
  localparam int unsigned LAT_CMP   = 1;
  localparam int unsigned LAT_F2I   = 6;
  localparam int unsigned LAT_9     = 6;
  localparam int unsigned LAT_OTHER = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } fpu_state_e;

endpackage

// File: rtl/fpu_latency_lut.sv
// Op -> fixed datapath latency. Also used by the issue-side stall logic so both ends agree on timing.
module fpu_latency_lut
  import fpu_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [3:0]       i_op,
  output logic [CNT_W-1:0] o_lat
);

  always_comb begin
    o_lat = CNT_W'(LAT_OTHER);
    case (i_op)
      FOP_ADD:   o_lat = CNT_W'(LAT_ADD);
      FOP_SUB:   o_lat = CNT_W'(LAT_SUB);
      FOP_MUL:   o_lat = CNT_W'(LAT_MUL);
      FOP_FMA:   o_lat = CNT_W'(LAT_FMA);
      FOP_SGNJ:  o_lat = CNT_W'(LAT_SGNJ);
      FOP_MINMX: o_lat = CNT_W'(LAT_MINMX);
      FOP_DIV:   o_lat = CNT_W'(LAT_DIV);
      FOP_CMP:   o_lat = CNT_W'(LAT_CMP);
      FOP_F2I:   o_lat = CNT_W'(LAT_F2I);
      FOP_9:     o_lat = CNT_W'(LAT_9);
      default:   o_lat = CNT_W'(LAT_OTHER);
    endcase
  end

endmodule

// File: rtl/fpu_completion_unit.sv
// FPU completion unit: accepts one op, times its fixed latency, then holds result/flags/tag until writeback.
// state | meaning
// IDLE  | no op in flight, nothing held
// BUSY  | op launched, counting up to its latency
// HOLD  | result captured, waiting for writeback to take it
module fpu_completion_unit
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int FLAG_W = 5,
  parameter int CNT_W  = 5
) (
  input  logic              i_clock,
  input  logic              i_clear,
  input  logic              i_req_valid,
  input  logic [3:0]        i_req_op,
  input  logic [TAG_W-1:0]  i_req_rd,
  output logic              o_req_ready,
  output logic              o_fpu_start,
  input  logic [DATA_W-1:0] i_res_data,
  input  logic [FLAG_W-1:0] i_res_flags,
  input  logic              i_flush,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [FLAG_W-1:0] o_wb_flags,
  output logic [TAG_W-1:0]  o_wb_rd,
  output logic              o_busy
);

  fpu_state_e        r_state;
  fpu_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_op;
  logic [TAG_W-1:0]  r_rd_pend;
  logic [DATA_W-1:0] r_wb_data;
  logic [FLAG_W-1:0] r_wb_flags;
  logic [TAG_W-1:0]  r_wb_rd;

  logic [CNT_W-1:0]  w_req_lat;
  logic [CNT_W-1:0]  w_cur_lat;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_capture;
  logic [TAG_W-1:0]  w_capture_rd;

  fpu_latency_lut #(.CNT_W(CNT_W)) u_lat_req (
    .i_op  (i_req_op),
    .o_lat (w_req_lat)
  );

  fpu_latency_lut #(.CNT_W(CNT_W)) u_lat_cur (
    .i_op  (r_op),
    .o_lat (w_cur_lat)
  );

  // clear gates ready so nothing is launched while the unit is held in reset
  always_comb begin
    w_req_ready  = ~i_clear & ~i_flush &
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_wb_ready));
    w_accept     = i_req_valid & w_req_ready;
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_capture_rd = (r_state == ST_BUSY) ? r_rd_pend : i_req_rd;

    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) begin
          if (w_req_lat == '0) begin
            w_state_nxt = ST_HOLD;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end else if ((r_state == ST_HOLD) && i_wb_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_count == w_cur_lat) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (i_flush) begin
      w_state_nxt = ST_IDLE;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_op       <= '0;
      r_rd_pend  <= '0;
      r_wb_data  <= '0;
      r_wb_flags <= '0;
      r_wb_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op      <= i_req_op;
        r_rd_pend <= i_req_rd;
        r_count   <= CNT_W'(1);
      end else if ((r_state == ST_BUSY) && (r_count < w_cur_lat)) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_capture) begin
        r_wb_data  <= i_res_data;
        r_wb_flags <= i_res_flags;
        r_wb_rd    <= w_capture_rd;
      end
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_fpu_start = w_accept;
  assign o_wb_valid  = (r_state == ST_HOLD);
  assign o_wb_data   = r_wb_data;
  assign o_wb_flags  = r_wb_flags;
  assign o_wb_rd     = r_wb_rd;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_completion_unit.sv
// Self-checking bench for fpu_completion_unit: directed scenarios plus random traffic against a cycle-indexed reference model.
module tb_fpu_completion_unit;

  logic        clk;
  logic        clear;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [4:0]  req_rd;
  logic        o_req_ready;
  logic        o_fpu_start;
  logic [31:0] res_data;
  logic [4:0]  res_flags;
  logic        flush;
  logic        o_wb_valid;
  logic        wb_ready;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_flags;
  logic [4:0]  o_wb_rd;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: an op in flight is known by the cycle its result is due
  logic        m_infl    = 1'b0;
  int          m_due     = 0;
  logic [4:0]  m_rd_pend = '0;
  logic        m_held    = 1'b0;
  logic [31:0] m_data    = '0;
  logic [4:0]  m_flags   = '0;
  logic [4:0]  m_rd      = '0;
  logic        m_zero    = 1'b1;

  fpu_completion_unit #(
    .DATA_W(32), .TAG_W(5), .FLAG_W(5), .CNT_W(5)
  ) dut (
    .i_clock     (clk),
    .i_clear     (clear),
    .i_req_valid (req_valid),
    .i_req_op    (req_op),
    .i_req_rd    (req_rd),
    .o_req_ready (o_req_ready),
    .o_fpu_start (o_fpu_start),
    .i_res_data  (res_data),
    .i_res_flags (res_flags),
    .i_flush     (flush),
    .o_wb_valid  (o_wb_valid),
    .i_wb_ready  (wb_ready),
    .o_wb_data   (o_wb_data),
    .o_wb_flags  (o_wb_flags),
    .o_wb_rd     (o_wb_rd),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd0: return 7;
      4'd1: return 7;
      4'd2: return 5;
      4'd3: return 6;
      4'd4: return 0;
      4'd5: return 1;
      4'd6: return 16;
      4'd7: return 1;
      4'd8: return 6;
      4'd9: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    logic e_ready;
    logic e_start;
    int   l;
    @(negedge clk);
    e_ready = !clear && !flush && !m_infl && (!m_held || wb_ready);
    e_start = req_valid && e_ready;
    check("req_ready", 64'(o_req_ready), 64'(e_ready));
    check("fpu_start", 64'(o_fpu_start), 64'(e_start));
    check("wb_valid",  64'(o_wb_valid),  64'(m_held));
    check("busy",      64'(o_busy),      64'(m_infl || m_held));
    if (m_held || m_zero) begin
      check("wb_data",  64'(o_wb_data),  64'(m_data));
      check("wb_flags", 64'(o_wb_flags), 64'(m_flags));
      check("wb_rd",    64'(o_wb_rd),    64'(m_rd));
    end
    @(posedge clk);
    if (clear) begin
      m_infl = 1'b0; m_held = 1'b0; m_zero = 1'b1;
      m_data = '0; m_flags = '0; m_rd = '0;
    end else if (flush) begin
      m_infl = 1'b0; m_held = 1'b0;
    end else begin
      if (m_held && wb_ready) m_held = 1'b0;
      if (m_infl && cyc == m_due) begin
        m_infl = 1'b0; m_held = 1'b1; m_zero = 1'b0;
        m_data = res_data; m_flags = res_flags; m_rd = m_rd_pend;
      end
      if (e_start) begin
        l = lat_of(req_op);
        if (l == 0) begin
          m_held = 1'b1; m_zero = 1'b0;
          m_data = res_data; m_flags = res_flags; m_rd = req_rd;
        end else begin
          m_infl = 1'b1; m_due = cyc + l; m_rd_pend = req_rd;
        end
      end
    end
    cyc++;
    #1;
  endtask

  // issue one op, feed data exactly at its due cycle, measure cycles until wb_valid
  task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] data,
                        input logic wbr);
    int l;
    int k;
    l = lat_of(op);
    req_valid = 1'b1; req_op = op; req_rd = rd; wb_ready = wbr;
    res_data  = (l == 0) ? data : $urandom;
    res_flags = 5'($urandom);
    cycle();
    req_valid = 1'b0; req_op = 4'($urandom); req_rd = 5'($urandom); wb_ready = 1'b0;
    k = 1;
    while (!o_wb_valid && k < 40) begin
      res_data  = (k == l) ? data : $urandom;
      res_flags = 5'($urandom);
      cycle();
      k++;
    end
    check("latency", 64'(k), 64'(l + 1));
    check("run_data", 64'(o_wb_data), 64'(data));
    check("run_rd",   64'(o_wb_rd),   64'(rd));
  endtask

  task automatic retire();
    wb_ready = 1'b1;
    cycle();
    wb_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; req_valid = 1'b1; req_op = 4'd2; req_rd = 5'd1;
    res_data = '0; res_flags = '0; flush = 1'b0; wb_ready = 1'b0;
    @(posedge clk); #1;

    // reset with req_valid asserted
    cycle();
    cycle();
    check("rst_ready", 64'(o_req_ready), 64'(0));
    check("rst_start", 64'(o_fpu_start), 64'(0));
    clear = 1'b0; req_valid = 1'b0;
    cycle();

    run_op(4'b0010, 5'd3, 32'h3F80_0000, 1'b0);
    retire();
    run_op(4'b0100, 5'd9, 32'h1234_5678, 1'b0);
    retire();
    run_op(4'b0110, 5'd17, 32'hCAFE_F00D, 1'b0);

    // held result stable for 4 cycles, then retire plus same-cycle accept
    repeat (4) begin
      res_data = $urandom; res_flags = 5'($urandom);
      cycle();
      check("hold_data", 64'(o_wb_data), 64'(32'hCAFE_F00D));
    end
    run_op(4'b0101, 5'd22, 32'h0BAD_BEEF, 1'b1);
    retire();

    // flush at count 3 of a 7-cycle op
    req_valid = 1'b1; req_op = 4'b0000; req_rd = 5'd7;
    cycle();
    req_valid = 1'b0;
    cycle(); cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (12) cycle();
    check("flush_busy", 64'(o_busy), 64'(0));

    // flush with a simultaneous request
    flush = 1'b1; req_valid = 1'b1; req_op = 4'b0100;
    #1;
    check("flush_nostart", 64'(o_fpu_start), 64'(0));
    cycle();
    flush = 1'b0; req_valid = 1'b0;
    cycle();

    run_op(4'b1111, 5'd30, 32'h7FC0_0000, 1'b0);
    retire();

    // clear in the middle of a long op
    req_valid = 1'b1; req_op = 4'b0110; req_rd = 5'd5;
    cycle();
    req_valid = 1'b0;
    repeat (3) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clr_busy",  64'(o_busy),     64'(0));
    check("clr_valid", 64'(o_wb_valid), 64'(0));
    check("clr_data",  64'(o_wb_data),  64'(0));
    cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 4'($urandom);
      req_rd    = 5'($urandom);
      wb_ready  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      clear     = ($urandom_range(0, 79) == 0);
      res_data  = $urandom;
      res_flags = 5'($urandom);
      cycle();
    end
    clear = 1'b0; flush = 1'b0; req_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
